// File: rtl/song_sequencer.sv
// Light-stick song sequencer: song selection, play/pause, player restart and time base,
// and end-of-song gap with optional auto-advance.
module song_sequencer #(
    parameter int unsigned NUM_SONGS      = 10,
    parameter int unsigned TICK_DIV       = 1000,
    parameter int unsigned RESTART_CYCLES = 4,
    parameter int unsigned GAP_TICKS      = 500,
    parameter bit          AUTO_ADVANCE   = 1'b1
) (
    input  logic       clock_play,
    input  logic       restart,
    input  logic       btn_play,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       song_end,
    output logic [3:0] song_no,
    output logic       player_restart,
    output logic       play_tick,
    output logic       playing,
    output logic       blank
);

    localparam int unsigned PreW  = $clog2(TICK_DIV);
    localparam int unsigned LoadW = $clog2(RESTART_CYCLES);
    localparam int unsigned GapW  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam int unsigned GapLastInt = (GAP_TICKS == 0) ? 0 : GAP_TICKS - 1;

    localparam logic [PreW-1:0]  TickLast = PreW'(TICK_DIV - 1);
    localparam logic [LoadW-1:0] LoadLast = LoadW'(RESTART_CYCLES - 1);
    localparam logic [GapW-1:0]  GapLast  = GapW'(GapLastInt);
    localparam logic [3:0]       SongLast = 4'(NUM_SONGS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StPlay,
        StPause,
        StGap
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        song_q, song_d;
    logic [PreW-1:0]   pre_q, pre_d;
    logic [GapW-1:0]   gap_q, gap_d;
    logic [LoadW-1:0]  load_q, load_d;
    logic              restart_q, restart_d;
    logic              tick_q, tick_d;
    logic              playing_q, playing_d;
    logic              blank_q, blank_d;

    logic       step;
    logic       tick;
    logic [3:0] song_inc;
    logic [3:0] song_dec;
    logic [3:0] song_step;

    always_comb begin
        state_d   = state_q;
        song_d    = song_q;
        pre_d     = pre_q;
        gap_d     = gap_q;
        load_d    = load_q;
        restart_d = 1'b0;
        tick_d    = 1'b0;
        playing_d = 1'b0;
        blank_d   = 1'b0;

        // Simultaneous next and prev cancel each other out.
        step      = btn_next ^ btn_prev;
        tick      = (pre_q == TickLast);
        song_inc  = (song_q == SongLast) ? 4'd0 : song_q + 4'd1;
        song_dec  = (song_q == 4'd0) ? SongLast : song_q - 4'd1;
        song_step = btn_next ? song_inc : song_dec;

        if (step) begin
            song_d = song_step;
        end

        if (step && state_q != StIdle) begin
            state_d = StLoad;
            load_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!step && btn_play) begin
                        state_d = StLoad;
                        load_d  = '0;
                    end
                end
                StLoad: begin
                    if (load_q == LoadLast) begin
                        state_d = StPlay;
                    end else begin
                        load_d = load_q + LoadW'(1);
                    end
                end
                StPlay: begin
                    if (btn_play) begin
                        state_d = StPause;
                    end else if (song_end) begin
                        state_d = StGap;
                        gap_d   = '0;
                    end
                end
                StPause: begin
                    if (btn_play) begin
                        state_d = StPlay;
                    end
                end
                StGap: begin
                    if (GAP_TICKS == 0 || (tick && gap_q == GapLast)) begin
                        if (AUTO_ADVANCE) begin
                            song_d  = song_inc;
                            state_d = StLoad;
                            load_d  = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else if (tick) begin
                        gap_d = gap_q + GapW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Prescaler runs in PLAY and GAP, freezes in PAUSE, is zero elsewhere.
        unique case (state_q)
            StPlay, StGap: pre_d = tick ? '0 : pre_q + PreW'(1);
            StPause:       pre_d = pre_q;
            default:       pre_d = '0;
        endcase
        if (state_d inside {StIdle, StLoad}) begin
            pre_d = '0;
        end

        // Outputs are registered from next state so they line up with state_q.
        restart_d = (state_d inside {StIdle, StLoad});
        tick_d    = (state_d == StLoad) || (state_d == StPlay && pre_d == TickLast);
        playing_d = (state_d == StPlay);
        blank_d   = (state_d inside {StIdle, StLoad, StGap});
    end

    always_ff @(posedge clock_play or negedge restart) begin
        if (!restart) begin
            state_q   <= StIdle;
            song_q    <= 4'd0;
            pre_q     <= '0;
            gap_q     <= '0;
            load_q    <= '0;
            restart_q <= 1'b1;
            tick_q    <= 1'b0;
            playing_q <= 1'b0;
            blank_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            song_q    <= song_d;
            pre_q     <= pre_d;
            gap_q     <= gap_d;
            load_q    <= load_d;
            restart_q <= restart_d;
            tick_q    <= tick_d;
            playing_q <= playing_d;
            blank_q   <= blank_d;
        end
    end

    assign song_no        = song_q;
    assign player_restart = restart_q;
    assign play_tick      = tick_q;
    assign playing        = playing_q;
    assign blank          = blank_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: one auto-advancing instance plus a
// non-advancing twin sharing the same stimulus for the end-of-song case.
module tb_song_sequencer;

    logic       clock_play;
    logic       restart;
    logic       btn_play;
    logic       btn_next;
    logic       btn_prev;
    logic       song_end;
    logic [3:0] song_no;
    logic       player_restart;
    logic       play_tick;
    logic       playing;
    logic       blank;
    logic [3:0] song_no_b;
    logic       player_restart_b;
    logic       play_tick_b;
    logic       playing_b;
    logic       blank_b;

    int n_checks = 0;
    int n_fail   = 0;

    song_sequencer #(
        .NUM_SONGS     (10),
        .TICK_DIV      (1000),
        .RESTART_CYCLES(4),
        .GAP_TICKS     (3),
        .AUTO_ADVANCE  (1'b1)
    ) dut (
        .clock_play    (clock_play),
        .restart       (restart),
        .btn_play      (btn_play),
        .btn_next      (btn_next),
        .btn_prev      (btn_prev),
        .song_end      (song_end),
        .song_no       (song_no),
        .player_restart(player_restart),
        .play_tick     (play_tick),
        .playing       (playing),
        .blank         (blank)
    );

    song_sequencer #(
        .NUM_SONGS     (10),
        .TICK_DIV      (1000),
        .RESTART_CYCLES(4),
        .GAP_TICKS     (3),
        .AUTO_ADVANCE  (1'b0)
    ) dut_b (
        .clock_play    (clock_play),
        .restart       (restart),
        .btn_play      (btn_play),
        .btn_next      (btn_next),
        .btn_prev      (btn_prev),
        .song_end      (song_end),
        .song_no       (song_no_b),
        .player_restart(player_restart_b),
        .play_tick     (play_tick_b),
        .playing       (playing_b),
        .blank         (blank_b)
    );

    initial begin
        clock_play = 1'b0;
        forever #5 clock_play = ~clock_play;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock_play);
        #1;
    endtask

    // Returns the sample index (first sample = 1) at which play_tick is seen.
    task automatic wait_tick(output int n);
        n = 1;
        while (!play_tick && n < 1100) begin
            cyc();
            n++;
        end
    endtask

    // Expects the current sample to be LOAD cycle 1; leaves on the first PLAY cycle.
    task automatic check_load(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_load_restart"}, 32'(player_restart), 32'd1);
            chk({tag, "_load_tick"}, 32'(play_tick), 32'd1);
            cyc();
        end
        chk({tag, "_exit_restart"}, 32'(player_restart), 32'd0);
        chk({tag, "_exit_playing"}, 32'(playing), 32'd1);
        chk({tag, "_exit_tick"}, 32'(play_tick), 32'd0);
    endtask

    initial begin
        int n;
        int cnt;

        restart  = 1'b1;
        btn_play = 1'b0;
        btn_next = 1'b0;
        btn_prev = 1'b0;
        song_end = 1'b0;
        #2 restart = 1'b0;
        cyc();
        cyc();
        chk("rst_song", 32'(song_no), 32'd0);
        chk("rst_restart", 32'(player_restart), 32'd1);
        chk("rst_tick", 32'(play_tick), 32'd0);
        chk("rst_playing", 32'(playing), 32'd0);
        chk("rst_blank", 32'(blank), 32'd1);
        restart = 1'b1;
        cyc();
        cyc();
        chk("idle_restart", 32'(player_restart), 32'd1);
        chk("idle_tick", 32'(play_tick), 32'd0);

        // Start: 4-cycle LOAD, then first tick on the 1000th PLAY cycle.
        btn_play = 1'b1;
        cyc();
        btn_play = 1'b0;
        check_load("start");
        chk("play_blank", 32'(blank), 32'd0);
        wait_tick(n);
        chk("first_tick_gap", 32'(n), 32'd1000);
        cyc();
        wait_tick(n);
        chk("second_tick_gap", 32'(n), 32'd1000);

        // Pause 300 cycles after a tick, hold, resume: tick 700 cycles later.
        repeat (300) cyc();
        btn_play = 1'b1;
        cyc();
        btn_play = 1'b0;
        chk("pause_playing", 32'(playing), 32'd0);
        chk("pause_blank", 32'(blank), 32'd0);
        chk("pause_restart", 32'(player_restart), 32'd0);
        cnt = 0;
        repeat (5000) begin
            cyc();
            cnt += int'(play_tick);
        end
        chk("pause_no_ticks", 32'(cnt), 32'd0);
        btn_play = 1'b1;
        cyc();
        btn_play = 1'b0;
        chk("resume_playing", 32'(playing), 32'd1);
        wait_tick(n);
        chk("resume_tick_gap", 32'(n), 32'd700);

        // Prev from song 0 wraps to 9 and reloads.
        btn_prev = 1'b1;
        cyc();
        btn_prev = 1'b0;
        chk("prev_wrap_song", 32'(song_no), 32'd9);
        check_load("prev");

        // End of song: GAP of 3 ticks; prescaler enters GAP at 1, so LOAD at sample 3000.
        song_end = 1'b1;
        cyc();
        song_end = 1'b0;
        chk("gap_blank", 32'(blank), 32'd1);
        chk("gap_playing", 32'(playing), 32'd0);
        chk("gap_tick", 32'(play_tick), 32'd0);
        n = 1;
        cnt = 0;
        while (!player_restart && n < 4000) begin
            cnt += int'(play_tick);
            cyc();
            n++;
        end
        chk("gap_length", 32'(n), 32'd3000);
        chk("gap_no_ticks", 32'(cnt), 32'd0);
        chk("adv_song", 32'(song_no), 32'd0);
        chk("noadv_song", 32'(song_no_b), 32'd9);
        chk("noadv_restart", 32'(player_restart_b), 32'd1);
        chk("noadv_tick", 32'(play_tick_b), 32'd0);
        chk("noadv_blank", 32'(blank_b), 32'd1);
        chk("noadv_playing", 32'(playing_b), 32'd0);
        check_load("adv");

        // next+prev together is ignored.
        btn_next = 1'b1;
        btn_prev = 1'b1;
        cyc();
        btn_next = 1'b0;
        btn_prev = 1'b0;
        chk("both_song", 32'(song_no), 32'd0);
        chk("both_playing", 32'(playing), 32'd1);

        // next beats song_end.
        btn_next = 1'b1;
        song_end = 1'b1;
        cyc();
        btn_next = 1'b0;
        song_end = 1'b0;
        chk("next_end_song", 32'(song_no), 32'd1);
        chk("next_end_restart", 32'(player_restart), 32'd1);
        chk("next_end_tick", 32'(play_tick), 32'd1);

        // next during LOAD cycle 2 restarts LOAD.
        cyc();
        btn_next = 1'b1;
        cyc();
        btn_next = 1'b0;
        chk("reload_song", 32'(song_no), 32'd2);
        check_load("reload");
        chk("reload_song_after", 32'(song_no), 32'd2);

        // Async reset between edges while play_tick is high.
        wait_tick(n);
        chk("pre_reset_tick", 32'(play_tick), 32'd1);
        #3 restart = 1'b0;
        #1;
        chk("async_song", 32'(song_no), 32'd0);
        chk("async_restart", 32'(player_restart), 32'd1);
        chk("async_tick", 32'(play_tick), 32'd0);
        chk("async_playing", 32'(playing), 32'd0);
        chk("async_blank", 32'(blank), 32'd1);
        cyc();
        #3 restart = 1'b1;
        cyc();
        cyc();
        chk("post_rst_song", 32'(song_no), 32'd0);
        chk("post_rst_playing", 32'(playing), 32'd0);
        chk("post_rst_tick", 32'(play_tick), 32'd0);

        // In IDLE, next only changes the song.
        btn_next = 1'b1;
        cyc();
        btn_next = 1'b0;
        chk("idle_next_song", 32'(song_no), 32'd1);
        chk("idle_next_tick", 32'(play_tick), 32'd0);
        chk("idle_next_blank", 32'(blank), 32'd1);
        btn_play = 1'b1;
        cyc();
        btn_play = 1'b0;
        check_load("idle_play");
        chk("idle_play_song", 32'(song_no), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Controller that sequences the light-stick keyframe player.
- Owns song selection, play/pause, the player's restart and time-base enable, and end-of-song auto-advance.
- Sits between the button front-end (already debounced, single-cycle pulses) and the keyframe player/ROM datapath.
- The player advances its keyframe time and ROM address only on cycles where play_tick is high.

Parameters:
- NUM_SONGS, 10: number of songs in ROM; valid song_no range 0..NUM_SONGS-1; must be 2..16.
- TICK_DIV, 1000: clock cycles per player time step; must be >= 2.
- RESTART_CYCLES, 4: cycles the player is held in restart on song load; must be >= 3.
- GAP_TICKS, 500: silent player-tick periods between songs after end of song.
- AUTO_ADVANCE, 1: 1 = go to the next song after the gap; 0 = return to IDLE.

Ports:
- clock_play, input, 1: single system clock; all logic on the rising edge.
- restart, input, 1: asynchronous, active-low reset.
- btn_play, input, 1: one-cycle pulse; start, pause or resume.
- btn_next, input, 1: one-cycle pulse; select the next song.
- btn_prev, input, 1: one-cycle pulse; select the previous song.
- song_end, input, 1: level from the player, high once the last keyframe (key time 12'hfff) is reached.
- song_no, output, 4: song index driven to the player/ROM base address.
- player_restart, output, 1: synchronous restart to the player, active-high.
- play_tick, output, 1: player advance enable, one cycle wide.
- playing, output, 1: high in PLAY only.
- blank, output, 1: high when the LED output must be forced dark (IDLE, LOAD, GAP).

Behaviour:
- Reset (restart low, async) values: state=IDLE, song_no=0, player_restart=1, play_tick=0, playing=0, blank=1, prescaler=0, gap counter=0, load counter=0.
- All outputs are registered.
- Prescaler: counts 0..TICK_DIV-1 in PLAY and GAP. It is frozen (value held) in PAUSE and cleared to 0 on LOAD entry. A "tick" is the cycle where prescaler==TICK_DIV-1.

State IDLE:
- player_restart=1, blank=1, play_tick=0.
- btn_play -> LOAD.
- btn_next/btn_prev change song_no only; state stays IDLE.

State LOAD:
- player_restart=1 and play_tick=1 on every cycle, so the player's synchronous restart is seen.
- Lasts exactly RESTART_CYCLES cycles.
- On the final cycle, player_restart is dropped on the next edge and the state goes to PLAY with prescaler=0.
- song_end is ignored in LOAD.

State PLAY:
- playing=1, blank=0.
- play_tick=1 on each tick cycle, else 0.
- btn_play -> PAUSE.
- song_end sampled high -> GAP; gap counter=0.

State PAUSE:
- play_tick=0, blank=0; the LED holds its last colour.
- btn_play -> PLAY, resuming with the held prescaler value.

State GAP:
- play_tick=0, blank=1.
- The gap counter increments on each tick.
- When the gap counter reaches GAP_TICKS-1 on a tick:
  - AUTO_ADVANCE=1: song_no advances and the state goes to LOAD.
  - AUTO_ADVANCE=0: the state goes to IDLE.
- GAP_TICKS=0 means advance on the first cycle in GAP.

Next/prev (in PLAY, PAUSE, GAP, LOAD):
- song_no = song_no±1 with wrap: NUM_SONGS-1 -> 0 on next, 0 -> NUM_SONGS-1 on prev.
- State goes to LOAD with a fresh RESTART_CYCLES count (LOAD restarts if already in LOAD).
- LOAD always exits to PLAY, including when the button was pressed from PAUSE.

Simultaneous events, in priority order:
- btn_next and btn_prev in the same cycle: both ignored.
- next/prev beats btn_play and song_end.
- btn_play beats song_end in PLAY, so PAUSE is taken. song_end is re-sampled on resume, since it is a level.

Other rules:
- song_no is never outside 0..NUM_SONGS-1.
- Reset asserted mid-operation immediately forces all outputs to their reset values.

Test Plan:
- Reset then btn_play: player_restart=1 and play_tick=1 for exactly 4 cycles; next, playing=1, and play_tick pulses every 1000 cycles, the first on the 1000th cycle after LOAD exit.
- Pause/resume: btn_play 300 cycles after a tick -> no play_tick while paused (hold 5000 cycles); btn_play again -> next play_tick exactly 700 cycles after resume.
- Song end with AUTO_ADVANCE=1, GAP_TICKS=3, song_no=9, NUM_SONGS=10: song_end high -> blank=1, no play_tick for 3000 cycles, then song_no=0 and a 4-cycle LOAD. With AUTO_ADVANCE=0 -> IDLE, song_no unchanged.
- Wrap and priority: btn_prev at song_no=0 -> song_no=9. btn_next+btn_prev together -> song_no unchanged. btn_next+song_end same cycle -> LOAD (not GAP), song_no+1.
- btn_next during LOAD cycle 2 -> LOAD restarts, player_restart high for 4 more cycles, song_no incremented once.
- Assert restart low mid-PLAY between clock edges -> outputs go to reset values with no clock edge; release -> IDLE, song_no=0.
